// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state enum, the NOP filler word and the default geometry.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSN            = 32'h0000_0013;
  localparam int          DEFAULT_DEPTH_WORDS = 256;
  localparam int          DEFAULT_WAIT_CYCLES = 1;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_resp_if.sv
// Fetch request/response handshake plus the boot-time word loader.
// master = PC side / loader, slave = instruction-memory responder.
interface imem_resp_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
// Never reset, so contents survive a responder reset.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_resp.sv
// Instruction fetch responder: WAIT_CYCLES+1 cycles accept->rsp_valid, response held under rsp_ready backpressure.
// IMEM_ERR_TRAP_EN: fault misaligned/out-of-range fetches with a NOP; otherwise indices wrap modulo DEPTH_WORDS.
module imem_resp
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input logic        CLK,
  input logic        nRST,
  imem_resp_if.slave bus
);

  localparam int          IW      = idx_width(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [31:0]   addr_q;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;

  logic          accept;
  logic          ld_ok;
  logic          fwd;
  logic          rd_err;
  logic          ld_err;
  logic [31:0]   rd_addr;
  logic [31:0]   mem_rdata;
  logic [31:0]   rd_word;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] ld_idx;
  logic          unused_ld_lsbs;

  assign accept         = bus.req_valid && req_ready;
  assign unused_ld_lsbs = ^bus.ld_addr[1:0];

  // With no wait states the read happens on the accept edge, so it must use the live request address.
  assign rd_addr = (state == IDLE) ? bus.req_addr : addr_q;

`ifdef IMEM_ERR_TRAP_EN
  assign rd_err = (rd_addr[1:0] != 2'b00) || (rd_addr[31:2] >= DEPTH_W);
  assign ld_err = (bus.ld_addr[31:2] >= DEPTH_W);
  assign rd_idx = IW'(rd_addr[31:2]);
  assign ld_idx = IW'(bus.ld_addr[31:2]);
`else
  logic unused_rd_lsbs;
  assign unused_rd_lsbs = ^rd_addr[1:0];
  assign rd_err = 1'b0;
  assign ld_err = 1'b0;
  assign rd_idx = IW'(rd_addr[31:2] % DEPTH_W);
  assign ld_idx = IW'(bus.ld_addr[31:2] % DEPTH_W);
`endif

  assign ld_ok = bus.ld_en && (state == IDLE) && !ld_err;
  // A load landing in the same cycle as a zero-wait accept must be visible to that fetch.
  assign fwd     = ld_ok && (ld_idx == rd_idx);
  assign rd_word = rd_err ? NOP_INSN : (fwd ? bus.ld_data : mem_rdata);

  imem_array #(
    .DEPTH (DEPTH_WORDS),
    .IW    (IW)
  ) u_array (
    .CLK   (CLK),
    .we    (ld_ok),
    .waddr (ld_idx),
    .wdata (bus.ld_data),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= !accept;
          if (accept) begin
            addr_q <= bus.req_addr;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= rd_word;
              rsp_err   <= rd_err;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= rd_word;
            rsp_err   <= rd_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_data  <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_imem_resp.sv
// Two responders (16 words / no wait states, 256 words / one wait state) driven with
// directed and random fetches, checked against an array model of the stored words.
module tb_imem_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK;
  logic nRST;

  int checks = 0;
  int errors = 0;

  imem_resp_if bus0();
  imem_resp_if bus1();

  logic        rq_v [2];
  logic [31:0] rq_a [2];
  logic        rr   [2];
  logic        le   [2];
  logic [31:0] la   [2];
  logic [31:0] ldat [2];
  logic        rdy  [2];
  logic        rv   [2];
  logic        re   [2];
  logic [31:0] rd   [2];

  logic [31:0] mem_m [2][256];

  assign bus0.req_valid = rq_v[0];
  assign bus0.req_addr  = rq_a[0];
  assign bus0.rsp_ready = rr[0];
  assign bus0.ld_en     = le[0];
  assign bus0.ld_addr   = la[0];
  assign bus0.ld_data   = ldat[0];
  assign rdy[0]         = bus0.req_ready;
  assign rv[0]          = bus0.rsp_valid;
  assign rd[0]          = bus0.rsp_data;
  assign re[0]          = bus0.rsp_err;

  assign bus1.req_valid = rq_v[1];
  assign bus1.req_addr  = rq_a[1];
  assign bus1.rsp_ready = rr[1];
  assign bus1.ld_en     = le[1];
  assign bus1.ld_addr   = la[1];
  assign bus1.ld_data   = ldat[1];
  assign rdy[1]         = bus1.req_ready;
  assign rv[1]          = bus1.rsp_valid;
  assign rd[1]          = bus1.rsp_data;
  assign re[1]          = bus1.rsp_err;

  imem_resp #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus0)
  );

  imem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic int unsigned depth_of(input int sel);
    return (sel == 1) ? 256 : 16;
  endfunction

  function automatic int wait_of(input int sel);
    return (sel == 1) ? 1 : 0;
  endfunction

  // Returns {err, data} the responder must produce for a fetch of address a.
  function automatic logic [32:0] model_read(input int sel, input logic [31:0] a);
    int unsigned w;
    w = int'(a[31:2]);
`ifdef IMEM_ERR_TRAP_EN
    if (a[1:0] != 2'b00 || w >= depth_of(sel)) return {1'b1, NOP};
    return {1'b0, mem_m[sel][w]};
`else
    return {1'b0, mem_m[sel][w % depth_of(sel)]};
`endif
  endfunction

  task automatic model_load(input int sel, input logic [31:0] a, input logic [31:0] d);
    int unsigned w;
    w = int'(a[31:2]);
`ifdef IMEM_ERR_TRAP_EN
    if (w < depth_of(sel)) mem_m[sel][w] = d;
`else
    mem_m[sel][w % depth_of(sel)] = d;
`endif
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
    end
  endtask

  task automatic load(input int sel, input logic [31:0] a, input logic [31:0] d);
    le[sel] = 1'b1;
    la[sel] = a;
    ldat[sel] = d;
    model_load(sel, a, d);
    @(posedge CLK); #1;
    le[sel] = 1'b0;
  endtask

  // mode 0: plain fetch, 1: load same word in the accept cycle, 2: load same word while waiting (ignored)
  task automatic fetch(input int sel, input logic [31:0] a, input int stall, input int mode,
                       output logic [31:0] got_d, output logic got_e);
    logic [32:0] ex;
    logic [31:0] nd;
    int n;
    int bad;
    n = 0;
    while (rdy[sel] !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq("req_ready_wait", 32'(rdy[sel]), 32'd1);
    nd = $urandom;
    rq_v[sel] = 1'b1;
    rq_a[sel] = a;
    rr[sel] = (stall == 0);
    if (mode == 1) begin
      le[sel] = 1'b1; la[sel] = a; ldat[sel] = nd;
      model_load(sel, a, nd);
    end
    @(posedge CLK); #1;
    rq_v[sel] = 1'b0;
    rq_a[sel] = $urandom;
    le[sel] = 1'b0;
    if (mode == 2) begin
      le[sel] = 1'b1; la[sel] = a; ldat[sel] = nd;
    end
    n = 1;
    bad = 0;
    while (rv[sel] !== 1'b1 && n < 40) begin
      if (rd[sel] !== 32'd0 || re[sel] !== 1'b0 || rdy[sel] !== 1'b0) bad++;
      @(posedge CLK); #1;
      le[sel] = 1'b0;
      n++;
    end
    le[sel] = 1'b0;
    check_eq("latency", 32'(n), 32'(wait_of(sel) + 1));
    check_eq("idle_outputs", 32'(bad), 32'd0);
    ex = model_read(sel, a);
    got_d = rd[sel];
    got_e = re[sel];
    check_eq("rsp_data", rd[sel], ex[31:0]);
    check_eq("rsp_err", 32'(re[sel]), 32'(ex[32]));
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK); #1;
      check_eq("stall_valid", 32'(rv[sel]), 32'd1);
      check_eq("stall_data", rd[sel], got_d);
      check_eq("stall_ready", 32'(rdy[sel]), 32'd0);
    end
    rr[sel] = 1'b1;
    @(posedge CLK); #1;
    check_eq("post_valid", 32'(rv[sel]), 32'd0);
    check_eq("post_data", rd[sel], 32'd0);
    check_eq("post_ready", 32'(rdy[sel]), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr(input int sel);
    int unsigned d;
    logic [31:0] a;
    d = depth_of(sel);
    case ($urandom_range(0, 4))
      0, 1:    a = 32'($urandom_range(0, d - 1)) << 2;
      2:       a = (32'($urandom_range(0, d - 1)) << 2) | 32'($urandom_range(1, 3));
      3:       a = 32'($urandom_range(d, 4 * d - 1)) << 2;
      default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] old;
    int          sel;

    for (int s = 0; s < 2; s++) begin
      rq_v[s] = 1'b0; rq_a[s] = '0; rr[s] = 1'b1;
      le[s] = 1'b0; la[s] = '0; ldat[s] = '0;
    end
    nRST = 1'b0;
    #1;
    check_eq("reset_valid", 32'(rv[1]), 32'd0);
    check_eq("reset_data", rd[1], 32'd0);
    check_eq("reset_err", 32'(re[1]), 32'd0);
    @(posedge CLK); #1;
    check_eq("reset_ready0", 32'(rdy[0]), 32'd0);
    check_eq("reset_ready1", 32'(rdy[1]), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check_eq("first_ready0", 32'(rdy[0]), 32'd1);
    check_eq("first_ready1", 32'(rdy[1]), 32'd1);

    for (int i = 0; i < 16; i++) load(0, 32'(i) << 2, $urandom);
    for (int i = 0; i < 256; i++) load(1, 32'(i) << 2, $urandom);

    // word 3 with one wait state
    load(1, 32'h0000_000C, 32'h0050_0093);
    fetch(1, 32'h0000_000C, 0, 0, d, e);
    check_eq("w3_data", d, 32'h0050_0093);
    check_eq("w3_err", 32'(e), 32'd0);

    // zero wait states, address 0
    fetch(0, 32'h0, 0, 0, d, e);

    // five cycles of backpressure
    fetch(1, 32'h0000_0010, 5, 0, d, e);

    // misaligned and one-past-the-end fetches
    load(1, 32'h0, 32'h1234_5678);
    fetch(1, 32'h0000_0002, 0, 0, d, e);
`ifdef IMEM_ERR_TRAP_EN
    check_eq("misalign_data", d, NOP);
    check_eq("misalign_err", 32'(e), 32'd1);
`else
    check_eq("misalign_data", d, 32'h1234_5678);
    check_eq("misalign_err", 32'(e), 32'd0);
`endif
    fetch(1, 32'd1024, 0, 0, d, e);
`ifdef IMEM_ERR_TRAP_EN
    check_eq("oob_data", d, NOP);
    check_eq("oob_err", 32'(e), 32'd1);
`else
    check_eq("oob_data", d, 32'h1234_5678);
    check_eq("oob_err", 32'(e), 32'd0);
`endif

    // reset while waiting aborts the fetch and keeps storage
    rq_v[1] = 1'b1; rq_a[1] = 32'h0000_000C; rr[1] = 1'b1;
    @(posedge CLK); #1;
    rq_v[1] = 1'b0;
    nRST = 1'b0;
    #1;
    check_eq("abort_valid", 32'(rv[1]), 32'd0);
    check_eq("abort_data", rd[1], 32'd0);
    check_eq("abort_ready", 32'(rdy[1]), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check_eq("abort_hold_valid", 32'(rv[1]), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check_eq("rerun_ready", 32'(rdy[1]), 32'd1);
    check_eq("rerun_valid", 32'(rv[1]), 32'd0);
    fetch(1, 32'h0000_000C, 0, 0, d, e);
    check_eq("kept_data", d, 32'h0050_0093);

    // load to the pending word while waiting is ignored
    old = mem_m[1][8];
    fetch(1, 32'h0000_0020, 0, 2, d, e);
    check_eq("wait_ld_old", d, old);
    fetch(1, 32'h0000_0020, 1, 0, d, e);
    check_eq("wait_ld_kept", d, old);

    // load and accept to the same word in one cycle
    fetch(0, 32'h0000_0014, 0, 1, d, e);
    fetch(1, 32'h0000_0018, 0, 1, d, e);

    for (int it = 0; it < 120; it++) begin
      sel = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) load(sel, rand_addr(sel), $urandom);
      fetch(sel, rand_addr(sel), int'($urandom_range(0, 3)),
            int'($urandom_range(0, (sel == 1) ? 2 : 1)), d, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit instruction words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: added wait states per fetch, legal range 0..15.
REQ-003 SHALL have port CLK, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port nRST, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: fetch request from PC side.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-007 SHALL have port req_addr, input, 32: byte address of instruction (PC value).
REQ-008 SHALL have port rsp_valid, output, 1: response word available.
REQ-009 SHALL have port rsp_ready, input, 1: consumer accepts response.
REQ-010 SHALL have port rsp_data, output, 32: fetched instruction word.
REQ-011 SHALL have port rsp_err, output, 1: fetch fault (misaligned or out of range).
REQ-012 SHALL have ports ld_en (input, 1), ld_addr (input, 32), ld_data (input, 32): boot-time word loader.

Function
REQ-013 SHALL implement FSM with states IDLE, WAIT, RESP.
REQ-014 SHALL drive req_ready=1 only in IDLE; request accepted when req_valid && req_ready.
REQ-015 SHALL latch req_addr on acceptance; later req_addr changes have no effect.
REQ-016 SHALL go IDLE->RESP on acceptance when WAIT_CYCLES=0, else IDLE->WAIT with wait counter loaded to WAIT_CYCLES-1.
REQ-017 SHALL decrement counter each WAIT cycle and go WAIT->RESP on the cycle counter is 0; latency acceptance->rsp_valid = WAIT_CYCLES+1 cycles.
REQ-018 SHALL read storage at transition into RESP and hold rsp_data/rsp_err stable while rsp_valid=1.
REQ-019 SHALL assert rsp_valid only in RESP; go RESP->IDLE when rsp_ready=1 (same-cycle back-to-back not allowed; next accept earliest one cycle later).
REQ-020 SHALL hold RESP indefinitely while rsp_ready=0 (backpressure).
REQ-021 SHALL index storage by latched_addr[31:2].
REQ-022 SHALL write ld_data to word ld_addr[31:2] when ld_en=1 and state is IDLE; ld_en in WAIT/RESP SHALL be ignored.
REQ-023 SHALL make a load and an acceptance in the same IDLE cycle to the same word return the newly loaded data.
REQ-024 SHALL drive rsp_data=0 and rsp_err=0 when rsp_valid=0.

Reset
REQ-025 SHALL on nRST=0 immediately force state IDLE, counter 0, req_ready=0 during reset, rsp_valid=0, rsp_data=0, rsp_err=0, latched address 0.
REQ-026 SHALL abort any in-flight fetch on reset with no response produced; storage contents SHALL NOT be cleared.
REQ-027 SHALL assert req_ready on the first rising CLK after nRST deasserts.

Configuration
REQ-028 SHALL, with IMEM_ERR_TRAP_EN defined, respond with rsp_err=1 and rsp_data=32'h00000013 (NOP) when latched addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; loader writes out of range ignored.
REQ-029 SHALL, without IMEM_ERR_TRAP_EN, tie rsp_err=0, ignore addr[1:0], and wrap word index modulo DEPTH_WORDS for reads and loads.

Structure
REQ-030 SHALL place state enum, NOP constant 32'h00000013, and default DEPTH/WAIT values in shared package imem_pkg.
REQ-031 SHALL isolate storage (one write port, one read port) in sub-module imem_array; FSM, counter, error check stay in imem_resp.

Verification
REQ-032 SHALL cover: load word 3 = 32'h00500093, WAIT_CYCLES=1, request addr 0x0C -> rsp_valid 2 cycles after accept, rsp_data=32'h00500093, rsp_err=0.
REQ-033 SHALL cover: WAIT_CYCLES=0, request addr 0x00 with rsp_ready=1 -> rsp_valid next cycle, req_ready back high one cycle after response handshake.
REQ-034 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable all 5 cycles, req_ready=0 throughout.
REQ-035 SHALL cover: with IMEM_ERR_TRAP_EN, request addr 0x02 and addr 4*DEPTH_WORDS -> rsp_err=1, rsp_data=32'h00000013; without macro addr 4*DEPTH_WORDS returns word 0, rsp_err=0.
REQ-036 SHALL cover: nRST pulsed low during WAIT -> rsp_valid never asserted for that fetch, outputs 0 immediately, stored words unchanged on a subsequent fetch.
REQ-037 SHALL cover: ld_en pulsed during WAIT to the pending word -> old data returned, word unchanged on re-fetch.
